// File: rtl/action_cfg_loader_if.sv
// action_cfg_loader_if: control-word stream, halt handshake and action RAM
// write port of one stage's action configuration loader.
// slave = loader side, master = control path / stage side.
interface action_cfg_loader_if #(
  parameter int unsigned CFG_W   = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned ENTRY_W = 4160
);
  logic [CFG_W-1:0]   cfg_data;
  logic               cfg_valid;
  logic               cfg_last;
  logic               cfg_ready;
  logic               halt_req;
  logic               halt_ack;
  logic               act_wr_en;
  logic [ADDR_W-1:0]  act_wr_addr;
  logic [ENTRY_W-1:0] act_wr_data;
  logic               busy;
  logic               err_drop;

  modport slave (
    input  cfg_data, cfg_valid, cfg_last, halt_ack,
    output cfg_ready, halt_req, act_wr_en, act_wr_addr, act_wr_data, busy, err_drop
  );

  modport master (
    output cfg_data, cfg_valid, cfg_last, halt_ack,
    input  cfg_ready, halt_req, act_wr_en, act_wr_addr, act_wr_data, busy, err_drop
  );
endinterface

// File: rtl/action_cfg_loader.sv
// action_cfg_loader: filters control frames by stage ID / opcode, assembles
// one action entry (C_NUM_PHVS sub-actions of ACT_LEN bits, sub-action 0 in
// the MSBs), stalls the stage via halt_req/halt_ack, then writes the entry
// to the action RAM with a one-cycle strobe.
// Optional feature macro: ACT_LOADER_HALT_EN (enables the halt handshake;
// when undefined, halt_req is tied 0 and the write follows the last word).
module action_cfg_loader #(
  parameter int unsigned STAGE_ID   = 0,
  parameter int unsigned ACT_LEN    = 64,
  parameter int unsigned C_NUM_PHVS = 65,
  parameter int unsigned CFG_W      = 32,
  parameter int unsigned ADDR_W     = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  action_cfg_loader_if.slave   bus
);

  localparam int unsigned ENTRY_W  = ACT_LEN * C_NUM_PHVS;
  localparam int unsigned NWORDS   = ENTRY_W / CFG_W;
  localparam logic [7:0]  OP_WRITE = 8'h01;
  localparam logic [7:0]  LAST_IDX = 8'(NWORDS - 1);

`ifdef ACT_LOADER_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DROP, S_WAIT_HALT, S_WRITE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DROP, S_WRITE} state_t;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_cnt;
  logic [ADDR_W-1:0]    r_addr;
  logic [ENTRY_W-1:0]   r_data;
  logic                 r_wr_en;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_hdr_match;
  logic                 w_hdr_load;
  logic                 w_shift;
  logic                 w_err;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DROP);
  assign w_accept    = bus.cfg_valid && w_ready;
  assign w_hdr_match = (bus.cfg_data[31:24] == 8'(STAGE_ID)) && (bus.cfg_data[23:16] == OP_WRITE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode, header filtering and malformed-frame detection
  always_comb begin
    w_next     = r_state;
    w_hdr_load = 1'b0;
    w_shift    = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hdr_match) begin
            if (bus.cfg_last) begin
              w_err = 1'b1;
            end else begin
              w_hdr_load = 1'b1;
              w_next     = S_LOAD;
            end
          end else if (!bus.cfg_last) begin
            w_next = S_DROP;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_IDX) begin
            if (bus.cfg_last) begin
`ifdef ACT_LOADER_HALT_EN
              w_next = S_WAIT_HALT;
`else
              w_next = S_WRITE;
`endif
            end else begin
              w_err  = 1'b1;
              w_next = S_DROP;
            end
          end else if (bus.cfg_last) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (w_accept && bus.cfg_last) w_next = S_IDLE;
      end
`ifdef ACT_LOADER_HALT_EN
      S_WAIT_HALT: begin
        if (bus.halt_ack) w_next = S_WRITE;
      end
`endif
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Entry assembly: address latch, word counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_hdr_load) begin
        r_cnt  <= '0;
        r_addr <= bus.cfg_data[ADDR_W-1:0];
      end else if (w_shift) begin
        r_cnt  <= r_cnt + 8'd1;
        r_data <= {r_data[ENTRY_W-CFG_W-1:0], bus.cfg_data};
      end
    end
  end

  // Registered status/strobe outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr_en <= (w_next == S_WRITE);
      r_busy  <= (w_next != S_IDLE);
      r_err   <= w_err;
    end
  end

`ifdef ACT_LOADER_HALT_EN
  logic r_halt_req;

  // halt_req covers the wait and the write cycle, dropping as the FSM idles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_halt_req <= 1'b0;
    else        r_halt_req <= (w_next == S_WAIT_HALT) || (w_next == S_WRITE);
  end

  assign bus.halt_req = r_halt_req;
`else
  logic w_unused_halt_ack;
  assign w_unused_halt_ack = bus.halt_ack;
  assign bus.halt_req      = 1'b0;
`endif

  assign bus.cfg_ready   = w_ready;
  assign bus.act_wr_en   = r_wr_en;
  assign bus.act_wr_addr = r_addr;
  assign bus.act_wr_data = r_data;
  assign bus.busy        = r_busy;
  assign bus.err_drop    = r_err;

endmodule

// File: tb/tb_action_cfg_loader.sv
// tb_action_cfg_loader: directed scenarios for action_cfg_loader at default
// parameters. Expectations follow ACT_LOADER_HALT_EN when it is defined.
// Status vector st = {cfg_ready, halt_req, act_wr_en, busy, err_drop}.
module tb_action_cfg_loader;
  localparam int CFG_W   = 32;
  localparam int ADDR_W  = 4;
  localparam int ENTRY_W = 64 * 65;
  localparam int NWORDS  = ENTRY_W / CFG_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  action_cfg_loader_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W)) bus ();

  action_cfg_loader #(
    .STAGE_ID(0), .ACT_LEN(64), .C_NUM_PHVS(65), .CFG_W(CFG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [4:0] st;
  assign st = {bus.cfg_ready, bus.halt_req, bus.act_wr_en, bus.busy, bus.err_drop};

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.act_wr_en === 1'b1) wr_cnt++;
    if (bus.err_drop === 1'b1)  err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ENTRY_W-1:0] build_exp(input logic [31:0] base);
    logic [ENTRY_W-1:0] e;
    e = '0;
    for (int k = 0; k < NWORDS; k++) e[(NWORDS-1-k)*CFG_W +: CFG_W] = base + 32'(k);
    return e;
  endfunction

  task automatic idle_bus();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    bus.cfg_data  = '0;
  endtask

  // presents one word and returns #1 after the edge that accepted it
  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    bus.cfg_data  = d;
    bus.cfg_last  = last;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    while (bus.cfg_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: cfg_ready got=%b exp=1 word=%h", bus.cfg_ready, d);
    end
    @(posedge clk); #1;
  endtask

  // header then nwords data words base+0..; cfg_last on word last_at (header if nwords==0)
  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base,
                            input int nwords, input int last_at);
    send(hdr, nwords == 0);
    for (int i = 1; i <= nwords; i++) send(base + 32'(i - 1), i == last_at);
    idle_bus();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // full good frame with halt_ack already in its desired state; checks write timing/content
  task automatic run_valid(input logic [3:0] addr, input logic [31:0] base);
    int w0, e0, bad;
    logic [ENTRY_W-1:0] exp;
    w0  = wr_cnt;
    e0  = err_cnt;
    exp = build_exp(base);
    send_frame({28'h0001000, addr}, base, NWORDS, NWORDS);
    @(negedge clk);
`ifdef ACT_LOADER_HALT_EN
    checks++;
    if (st !== 5'b01010) begin errors++; $display("FAIL valid_n1_status got=%b exp=01010", st); end
    @(negedge clk);
    checks++;
    if (st !== 5'b01110) begin errors++; $display("FAIL valid_n2_status got=%b exp=01110", st); end
`else
    checks++;
    if (st !== 5'b00110) begin errors++; $display("FAIL valid_n1_status got=%b exp=00110", st); end
`endif
    checks++;
    if (bus.act_wr_addr !== addr) begin
      errors++; $display("FAIL valid_addr got=%h exp=%h", bus.act_wr_addr, addr);
    end
    bad = -1;
    for (int k = 0; k < NWORDS; k++)
      if (bad < 0 && bus.act_wr_data[(NWORDS-1-k)*CFG_W +: CFG_W] !== exp[(NWORDS-1-k)*CFG_W +: CFG_W]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL valid_data word=%0d got=%h exp=%h", bad,
               bus.act_wr_data[(NWORDS-1-bad)*CFG_W +: CFG_W], exp[(NWORDS-1-bad)*CFG_W +: CFG_W]);
    end
    checks++;
    if (bus.act_wr_data[31:0] !== base + 32'(NWORDS - 1)) begin
      errors++; $display("FAIL valid_low_word got=%h exp=%h", bus.act_wr_data[31:0], base + 32'(NWORDS - 1));
    end
    checks++;
    if (bus.act_wr_data[ENTRY_W-1 -: CFG_W] !== base) begin
      errors++; $display("FAIL valid_top_word got=%h exp=%h", bus.act_wr_data[ENTRY_W-1 -: CFG_W], base);
    end
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL valid_after_status got=%b exp=10000", st); end
    settle(2);
    checks++;
    if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL valid_pulses wr=%0d err=%0d exp wr=1 err=0", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    bus.halt_ack = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL reset_status got=%b exp=10000", st); end
    checks++;
    if (bus.act_wr_addr !== '0 || bus.act_wr_data !== '0) begin
      errors++; $display("FAIL reset_regs addr=%h low=%h exp 0", bus.act_wr_addr, bus.act_wr_data[31:0]);
    end
    rst_n = 1'b1;
    settle(1);
  endtask

  task automatic test_valid_frame();
    bus.halt_ack = 1'b1;
    run_valid(4'd3, 32'h0);
  endtask

  task automatic test_stage_mismatch();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(32'h05010003, 32'h2000, NWORDS - 1, 0);
    @(negedge clk);
    checks++;
    if (st !== 5'b10010) begin errors++; $display("FAIL mismatch_mid_status got=%b exp=10010", st); end
    settle(1);
    send(32'h2000 + 32'(NWORDS - 1), 1'b1);
    idle_bus();
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL mismatch_end_status got=%b exp=10000", st); end
    settle(2);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL mismatch_pulses wr=%0d err=%0d exp 0 0", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_short_frame();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(32'h00010003, 32'h3000, 10, 10);
    @(negedge clk);
    checks++;
    if (st !== 5'b10001) begin errors++; $display("FAIL short_err_status got=%b exp=10001", st); end
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL short_err_width got=%b exp=10000", st); end
    settle(1);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL short_pulses wr=%0d err=%0d exp wr=0 err=1", wr_cnt - w0, err_cnt - e0);
    end
    run_valid(4'd5, 32'h1000);
  endtask

  task automatic test_header_boundaries();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(32'h00010003, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (st !== 5'b10001) begin errors++; $display("FAIL hdr_only_status got=%b exp=10001", st); end
    settle(1);
    send_frame(32'h07010002, 32'h0, 0, 0);
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL hdr_other_last_status got=%b exp=10000", st); end
    settle(1);
    send_frame(32'h00020003, 32'h10, 2, 2);
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL hdr_opcode_status got=%b exp=10000", st); end
    settle(2);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL hdr_pulses wr=%0d err=%0d exp wr=0 err=1", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_halt_stall();
    bus.halt_ack = 1'b0;
`ifdef ACT_LOADER_HALT_EN
    send_frame(32'h00010009, 32'h4000, NWORDS, NWORDS);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (st !== 5'b01010) begin errors++; $display("FAIL stall_cycle%0d got=%b exp=01010", c, st); end
    end
    bus.halt_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (st !== 5'b01110 || bus.act_wr_addr !== 4'd9) begin
      errors++; $display("FAIL stall_write st=%b addr=%h exp 01110 9", st, bus.act_wr_addr);
    end
    checks++;
    if (bus.act_wr_data[31:0] !== 32'h4000 + 32'(NWORDS - 1)) begin
      errors++; $display("FAIL stall_low_word got=%h exp=%h", bus.act_wr_data[31:0], 32'h4000 + 32'(NWORDS - 1));
    end
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL stall_after got=%b exp=10000", st); end
    settle(1);
`else
    run_valid(4'd9, 32'h4000);
    bus.halt_ack = 1'b1;
`endif
  endtask

  task automatic test_reset_abort();
    int w0;
    w0 = wr_cnt;
    send_frame(32'h00010006, 32'h6000, 50, 0);
    @(negedge clk);
    checks++;
    if (st !== 5'b10010) begin errors++; $display("FAIL rst_frame_pre got=%b exp=10010", st); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 5'b10000 || bus.act_wr_data !== '0) begin
      errors++; $display("FAIL rst_frame_async st=%b low=%h exp 10000 0", st, bus.act_wr_data[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle(1);
`ifdef ACT_LOADER_HALT_EN
    bus.halt_ack = 1'b0;
    send_frame(32'h00010002, 32'h5000, NWORDS, NWORDS);
    @(negedge clk);
    checks++;
    if (st !== 5'b01010) begin errors++; $display("FAIL rst_halt_pre got=%b exp=01010", st); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL rst_halt_async got=%b exp=10000", st); end
    bus.halt_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif
    settle(3);
    @(negedge clk);
    checks++;
    if (st !== 5'b10000 || bus.act_wr_addr !== '0 || bus.act_wr_data !== '0) begin
      errors++; $display("FAIL rst_release st=%b addr=%h low=%h exp 10000 0 0", st, bus.act_wr_addr, bus.act_wr_data[31:0]);
    end
    checks++;
    if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rst_no_write wr=%0d exp=0", wr_cnt - w0); end
    settle(1);
  endtask

  task automatic test_long_frame();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(32'h00010004, 32'h7000, NWORDS, 0);
    @(negedge clk);
    checks++;
    if (st !== 5'b10011) begin errors++; $display("FAIL long_err_status got=%b exp=10011", st); end
    settle(1);
    send(32'hDEADBEEF, 1'b1);
    idle_bus();
    @(negedge clk);
    checks++;
    if (st !== 5'b10000) begin errors++; $display("FAIL long_end_status got=%b exp=10000", st); end
    settle(2);
    checks++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL long_pulses wr=%0d err=%0d exp wr=0 err=1", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    bus.halt_ack = 1'b1;
    send(32'h01010000, 1'b0);
    send(32'h00000001, 1'b0);
    send(32'h00000002, 1'b1);
    run_valid(4'd12, 32'h8000);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_stage_mismatch();
    test_short_frame();
    test_header_boundaries();
    test_halt_stall();
    test_reset_abort();
    test_long_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
